// File: rtl/gps_pkg.sv
// gps_pkg: definitions shared across the GPS NMEA receive path.
//
// Contents:
//   CLK_FREQ_HZ  system clock frequency in Hz
//   B            byte width of the serial link and the NMEA parser
//   ASCII_*      NMEA framing characters ('$', ',', '*', CR, LF)
//   ST_*         gps_uart_rx state encodings
//   maj3()       2-of-3 majority vote, used when the receiver is built
//                with GPS_UART_RX_MAJORITY_EN
package gps_pkg;

  localparam int CLK_FREQ_HZ = 100_000_000;
  localparam int B           = 8;

  localparam logic [7:0] ASCII_DOLLAR = 8'h24;
  localparam logic [7:0] ASCII_COMMA  = 8'h2C;
  localparam logic [7:0] ASCII_STAR   = 8'h2A;
  localparam logic [7:0] ASCII_CR     = 8'h0D;
  localparam logic [7:0] ASCII_LF     = 8'h0A;

  // Receiver FSM encodings
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/gps_baud_tick.sv
// gps_baud_tick: divide-by-DIV strobe generator for UART oversampling.
//
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous, active-high
//   clear  holds the divider at zero and suppresses tick; releasing it
//          restarts the divider so the first tick lands DIV clocks later
//   tick   one-cycle pulse every DIV clocks while clear is low
module gps_baud_tick #(
  parameter int DIV = 651
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_count;
  logic          w_wrap;

  assign w_wrap = (r_count == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear || w_wrap) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign tick = !clear && w_wrap;

endmodule

// File: rtl/gps_uart_rx.sv
// gps_uart_rx: oversampling 8N1 UART receiver feeding the GPZDA parser.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-high
//   rx           raw UART line (idle high), asynchronous to clock
//   data         last correctly framed byte, held until the next load
//   load         one-cycle strobe: data is newly valid
//   frame_error  one-cycle strobe: stop bit sampled low, data unchanged
//
// Build option:
//   GPS_UART_RX_MAJORITY_EN  each bit decision is the 2-of-3 majority of
//                            the samples at ticks OVERSAMPLE/2-1, /2, /2+1
//                            of the bit (one tick more latency). Without
//                            it a single sample at tick OVERSAMPLE/2 is used.
module gps_uart_rx #(
  parameter int CLK_FREQ   = gps_pkg::CLK_FREQ_HZ,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int B          = gps_pkg::B
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         rx,
  output logic [B-1:0] data,
  output logic         load,
  output logic         frame_error
);

  import gps_pkg::*;

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int IW  = $clog2(B + 1);

  // The start bit is judged at its middle; every later bit is judged one
  // full bit period after the previous decision. With majority voting the
  // decision falls on the last of the three samples, one tick later.
`ifdef GPS_UART_RX_MAJORITY_EN
  localparam logic [SW-1:0] HALF_TICK = SW'(OVERSAMPLE / 2);
`else
  localparam logic [SW-1:0] HALF_TICK = SW'(OVERSAMPLE / 2 - 1);
`endif
  localparam logic [SW-1:0] LAST_TICK = SW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(B - 1);

  logic          r_rx_meta;
  logic          r_rx_s;
  logic [2:0]    r_state;
  logic [SW-1:0] r_sample_cnt;
  logic [IW-1:0] r_bit_idx;
  logic [B-1:0]  r_shift;
  logic [B-1:0]  r_data;
  logic          r_load;
  logic          r_frame_error;

  logic w_tick;
  logic w_tick_clear;
  logic w_bit_val;

  // Two-flop synchroniser; resets to the idle level so no false start
  // bit is seen when reset is released.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Divider is parked while idle so the tick phase is anchored to the
  // start-bit falling edge of every frame.
  assign w_tick_clear = (r_state == ST_IDLE);

  gps_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clock (clock),
    .reset (reset),
    .clear (w_tick_clear),
    .tick  (w_tick)
  );

`ifdef GPS_UART_RX_MAJORITY_EN
  // Line value at the two preceding ticks; with the current value this
  // gives the three votes centred on the bit middle.
  logic [1:0] r_hist;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hist <= 2'b11;
    end else if (w_tick) begin
      r_hist <= {r_hist[0], r_rx_s};
    end
  end

  assign w_bit_val = maj3(r_hist[1], r_hist[0], r_rx_s);
`else
  assign w_bit_val = r_rx_s;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_sample_cnt  <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_data        <= '0;
      r_load        <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_load        <= 1'b0;
      r_frame_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_sample_cnt <= '0;
          r_bit_idx    <= '0;
          if (!r_rx_s) begin
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_tick) begin
            if (r_sample_cnt == HALF_TICK) begin
              r_sample_cnt <= '0;
              // A line that is high again mid start bit was only a glitch.
              r_state      <= w_bit_val ? ST_IDLE : ST_DATA;
            end else begin
              r_sample_cnt <= r_sample_cnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_sample_cnt == LAST_TICK) begin
              r_sample_cnt <= '0;
              r_shift      <= {w_bit_val, r_shift[B-1:1]};
              if (r_bit_idx == LAST_BIT) begin
                r_state <= ST_STOP;
              end else begin
                r_bit_idx <= r_bit_idx + 1'b1;
              end
            end else begin
              r_sample_cnt <= r_sample_cnt + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            if (r_sample_cnt == LAST_TICK) begin
              r_sample_cnt <= '0;
              // Returning to IDLE mid stop bit lets a start bit that
              // follows with no idle gap be caught.
              if (w_bit_val) begin
                r_data  <= r_shift;
                r_load  <= 1'b1;
                r_state <= ST_IDLE;
              end else begin
                r_frame_error <= 1'b1;
                r_state       <= ST_WAIT_IDLE;
              end
            end else begin
              r_sample_cnt <= r_sample_cnt + 1'b1;
            end
          end
        end
        ST_WAIT_IDLE: begin
          // Break or stuck-low line must not be read as a start bit.
          if (r_rx_s) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign data        = r_data;
  assign load        = r_load;
  assign frame_error = r_frame_error;

endmodule

// File: tb/tb_gps_uart_rx.sv
// tb_gps_uart_rx: directed and randomized bench for gps_uart_rx.
// The line rate is raised so that a frame is 640 clocks (4 clocks per
// oversample tick); all expectations are derived from the frame timing
// rules in bit periods and from the bytes sent.
// Honours GPS_UART_RX_MAJORITY_EN for the expected spike result and latency.
module tb_gps_uart_rx;
  import gps_pkg::*;

  localparam int CLK_FREQ = 100_000_000;
  localparam int BAUD     = 1_562_500;
  localparam int OS       = 16;
  localparam int BW       = 8;
  localparam int DIV      = CLK_FREQ / (BAUD * OS);
  localparam int BITC     = DIV * OS;
`ifdef GPS_UART_RX_MAJORITY_EN
  localparam int EXTRA    = DIV;
`else
  localparam int EXTRA    = 0;
`endif
  // 9.5 bit periods from the start edge to the mid stop bit, plus the
  // synchroniser (2), the start-detect clock (1), and any vote delay.
  localparam int LAT = 3 + (OS / 2) * DIV + (BW + 1) * BITC + EXTRA;

  logic          clock = 1'b0;
  logic          reset;
  logic          rx;
  logic [BW-1:0] data;
  logic          load;
  logic          frame_error;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int fe_cnt   = 0;
  logic prev_load = 1'b0;
  logic prev_fe   = 1'b0;

  logic [7:0] got_q[$];
  int         got_cyc_q[$];

  gps_uart_rx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS),
    .B          (BW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx),
    .data        (data),
    .load        (load),
    .frame_error (frame_error)
  );

  initial forever #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: records every received byte and frame error.
  always @(negedge clock) begin
    if (load || frame_error) begin
      check("strobe_exclusive", 32'(load & frame_error), 32'd0);
      if (load) begin
        check("load_width", 32'(prev_load), 32'd0);
        got_q.push_back(data);
        got_cyc_q.push_back(cyc);
        $display("rx byte 0x%02h at cycle %0d", data, cyc);
      end
      if (frame_error) begin
        check("fe_width", 32'(prev_fe), 32'd0);
        fe_cnt++;
        $display("frame error at cycle %0d", cyc);
      end
    end
    prev_load = load;
    prev_fe   = frame_error;
  end

  // Advance n clocks, landing 1 ns after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drive one 8N1 frame; spike_bit >= 0 puts a one-clock low pulse at
  // the exact middle of that data bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_v,
                            input int spike_bit, output int start_cyc);
    start_cyc = cyc;
    rx = 1'b0;
    step(BITC);
    for (int i = 0; i < BW; i++) begin
      rx = b[i];
      if (i == spike_bit) begin
        step(BITC / 2);
        rx = 1'b0;
        step(1);
        rx = b[i];
        step(BITC / 2 - 1);
      end else begin
        step(BITC);
      end
    end
    rx = stop_v;
    step(BITC);
  endtask

  logic [7:0] msg [7];
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         s;
  int         exp_fe;
  logic [7:0] last_good;
  logic [7:0] rb;
  logic       sv;

  initial begin
    msg = '{ASCII_DOLLAR, 8'h47, 8'h50, 8'h5A, 8'h44, 8'h41, ASCII_COMMA};
    rx    = 1'b1;
    reset = 1'b1;
    step(5);
    check("reset_data", 32'(data), 32'd0);
    check("reset_load", 32'(load), 32'd0);
    check("reset_fe", 32'(frame_error), 32'd0);
    reset = 1'b0;
    step(2 * BITC);

    // Single '$'
    got_q.delete(); got_cyc_q.delete();
    send_frame(ASCII_DOLLAR, 1'b1, -1, s);
    step(BITC);
    check("dollar_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) begin
      check("dollar_data", 32'(got_q[0]), 32'h24);
      check("dollar_latency", 32'(got_cyc_q[0] - s), 32'(LAT));
    end
    check("dollar_fe", 32'(fe_cnt), 32'd0);

    // "$GPZDA," with no idle gap between frames
    got_q.delete(); got_cyc_q.delete();
    for (int i = 0; i < 7; i++) send_frame(msg[i], 1'b1, -1, s);
    step(BITC);
    check("gpzda_count", 32'(got_q.size()), 32'd7);
    for (int i = 0; i < 7; i++)
      if (i < got_q.size()) check("gpzda_data", 32'(got_q[i]), 32'(msg[i]));

    // Short low glitch on the idle line
    got_q.delete(); got_cyc_q.delete();
    rx = 1'b0;
    step(3);
    rx = 1'b1;
    step(2 * BITC);
    check("glitch_load", 32'(got_q.size()), 32'd0);
    check("glitch_fe", 32'(fe_cnt), 32'd0);
    send_frame(8'h30, 1'b1, -1, s);
    step(BITC);
    check("after_glitch_count", 32'(got_q.size()), 32'd1);
    check("after_glitch_data", 32'(data), 32'h30);

    // Stop bit low, line held low, then released
    got_q.delete(); got_cyc_q.delete();
    send_frame(8'h55, 1'b0, -1, s);
    step(5 * BITC);
    rx = 1'b1;
    step(2 * BITC);
    check("ferr_count", 32'(fe_cnt), 32'd1);
    check("ferr_no_load", 32'(got_q.size()), 32'd0);
    check("ferr_data_held", 32'(data), 32'h30);
    send_frame(8'h31, 1'b1, -1, s);
    step(BITC);
    check("after_ferr_count", 32'(got_q.size()), 32'd1);
    check("after_ferr_data", 32'(data), 32'h31);

    // Reset in the middle of bit 4 of 0x47
    got_q.delete(); got_cyc_q.delete();
    fe_cnt = 0;
    rb = 8'h47;
    rx = 1'b0;
    step(BITC);
    for (int i = 0; i < 4; i++) begin
      rx = rb[i];
      step(BITC);
    end
    rx = rb[4];
    step(BITC / 2);
    reset = 1'b1;
    #1;
    check("midreset_data", 32'(data), 32'd0);
    check("midreset_load", 32'(load), 32'd0);
    check("midreset_fe", 32'(frame_error), 32'd0);
    rx = 1'b1;
    step(4);
    reset = 1'b0;
    step(2 * BITC);
    check("midreset_no_strobe", 32'(got_q.size() + fe_cnt), 32'd0);
    send_frame(8'h5A, 1'b1, -1, s);
    step(BITC);
    check("after_reset_count", 32'(got_q.size()), 32'd1);
    check("after_reset_data", 32'(data), 32'h5A);

    // One-clock spike at the middle of bit 0 of 0xFF
    got_q.delete(); got_cyc_q.delete();
    send_frame(8'hFF, 1'b1, 0, s);
    step(BITC);
    check("spike_count", 32'(got_q.size()), 32'd1);
`ifdef GPS_UART_RX_MAJORITY_EN
    check("spike_data", 32'(data), 32'hFF);
`else
    check("spike_data", 32'(data), 32'hFE);
`endif

    // Random bytes, random gaps, occasional bad stop bit
    got_q.delete(); got_cyc_q.delete();
    fe_cnt = 0;
    exp_fe = 0;
    last_good = data;
    for (int n = 0; n < 20; n++) begin
      rb = 8'($urandom_range(0, 255));
      sv = ($urandom_range(0, 4) != 0);
      send_frame(rb, sv, -1, s);
      if (sv) begin
        exp_q.push_back(rb);
        start_q.push_back(s);
        last_good = rb;
      end else begin
        exp_fe++;
        rx = 1'b1;
        step(BITC);
      end
      step($urandom_range(0, 2) * BITC);
    end
    step(BITC);
    check("rand_count", 32'(got_q.size()), 32'(exp_q.size()));
    check("rand_fe", 32'(fe_cnt), 32'(exp_fe));
    check("rand_last_data", 32'(data), 32'(last_good));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        check("rand_data", 32'(got_q[i]), 32'(exp_q[i]));
        check("rand_latency", 32'(got_cyc_q[i] - start_q[i]), 32'(LAT));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
